kernel_chunk_sequencer: RTL and testbench
=========================================

KERNEL_CHUNK_SEQUENCER -- requirements
Module: kernel_chunk_sequencer

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 64, meaning the byte address width.
REQ-002 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, meaning the byte-length width.
REQ-003 SHALL have parameter C_CHUNK_BYTES, default 4096, meaning the maximum bytes per datapath launch; it is a power of two and a multiple of C_BEAT_BYTES.
REQ-004 SHALL have parameter C_BEAT_BYTES, default 64, meaning the AXI beat size in bytes.
REQ-005 SHALL have port ap_clk, input, 1 bit: clock.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous, active-high; clock ap_clk.
REQ-007 SHALL have port ap_start, input, 1 bit: host start level.
REQ-008 SHALL have port ap_idle, output, 1 bit: block idle.
REQ-009 SHALL have ports ap_done and ap_ready, outputs, 1 bit each: job-complete pulse.
REQ-010 SHALL have port ctrl_base_addr, input, C_ADDR_WIDTH bits: job start byte address.
REQ-011 SHALL have port ctrl_length_bytes, input, C_XFER_SIZE_WIDTH bits: total job bytes.
REQ-012 SHALL have port dp_start, output, 1 bit: one-cycle launch pulse to the vadd datapath.
REQ-013 SHALL have port dp_addr_offset, output, C_ADDR_WIDTH bits: chunk address.
REQ-014 SHALL have port dp_xfer_size_in_bytes, output, C_XFER_SIZE_WIDTH bits: chunk size.
REQ-015 SHALL have port dp_done, input, 1 bit: datapath chunk-complete pulse.
REQ-016 SHALL have port chunk_count, output, 16 bits: chunks completed in the current or last job.
REQ-017 SHALL have port proto_err, output, 1 bit: sticky flag for an unexpected dp_done.

Function
REQ-018 SHALL register ap_start as ap_start_r and form start_pulse = ap_start & ~ap_start_r.
REQ-019 SHALL implement FSM states IDLE, LAUNCH, WAIT and DONE, with all outputs driven from registers.
REQ-020 In IDLE on start_pulse, SHALL capture ctrl_base_addr into cur_addr, set remaining to ctrl_length_bytes rounded up to a multiple of C_BEAT_BYTES (computed at C_XFER_SIZE_WIDTH+1 bits, no wrap), clear chunk_count, and go to DONE if remaining==0, else to LAUNCH.
REQ-021 SHALL assert dp_start for exactly the one cycle spent in LAUNCH, with dp_addr_offset=cur_addr and dp_xfer_size_in_bytes=min(remaining, C_CHUNK_BYTES); the next state is WAIT.
REQ-022 SHALL hold dp_addr_offset and dp_xfer_size_in_bytes stable from LAUNCH until dp_done is accepted in WAIT.
REQ-023 In WAIT on dp_done, SHALL add the chunk size to cur_addr, subtract it from remaining, and increment chunk_count (saturating at 0xFFFF); the next state is DONE if the new remaining==0, else LAUNCH.
REQ-024 In DONE, SHALL assert ap_done=ap_ready=1 for one cycle and return to IDLE.
REQ-025 SHALL drive ap_idle=1 only in IDLE; ap_idle falls the cycle after start_pulse and rises the cycle after DONE.
REQ-026 SHALL ignore start_pulse outside IDLE; the job is not queued.
REQ-027 SHALL ignore dp_done arriving in IDLE, LAUNCH or DONE, and SHALL set proto_err in that case; proto_err clears only on reset.
REQ-028 The minimum chunk-to-chunk interval SHALL be 2 cycles (WAIT+dp_done -> LAUNCH -> dp_start).
REQ-029 A start_pulse coinciding with DONE SHALL be ignored; the host re-raises ap_start after ap_done.

Reset
REQ-030 On areset, SHALL enter IDLE with ap_idle=1, ap_done=ap_ready=dp_start=0, dp_addr_offset=0, dp_xfer_size_in_bytes=0, chunk_count=0, proto_err=0 and ap_start_r=0.
REQ-031 areset mid-job SHALL abort immediately to IDLE with no ap_done, even if the datapath later returns dp_done (which sets proto_err).

Structure
REQ-032 SHALL place the FSM state enum and the default C_CHUNK_BYTES and C_BEAT_BYTES constants in the shared package kernel_ctrl_pkg.
REQ-033 SHALL be a single module with no sub-modules, instantiated between the kernel top-level control logic and rtl_kernel_wizard_1_example_vadd.

Verification
REQ-034 With base=0x1000 and len=16384, the bench SHALL observe 4 dp_start pulses at addresses 0x1000, 0x2000, 0x3000 and 0x4000, each of size 4096, then ap_done with chunk_count=4.
REQ-035 With len=5000, the bench SHALL observe chunks of 4096 and 960 (5000 rounded up to 5056), then ap_done with chunk_count=2.
REQ-036 With len=0, the bench SHALL observe no dp_start and ap_done 2 cycles after start_pulse.
REQ-037 With ap_start held high after ap_done, the bench SHALL observe no second job; after a 0->1 transition a new job SHALL start.
REQ-038 With dp_done injected while IDLE, the bench SHALL observe proto_err=1 and no state change.
REQ-039 With areset asserted during WAIT of chunk 2, the bench SHALL observe ap_idle=1 the next cycle, all outputs at reset values, and no ap_done.

Source files
------------

// File: rtl/kernel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// kernel_ctrl_pkg
// Shared definitions for the kernel control slice: the chunk sequencer FSM
// state encoding and the default chunk / AXI beat sizes used by the vadd
// kernel.
// ---------------------------------------------------------------------------
package kernel_ctrl_pkg;

  // Chunk sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  // Largest transfer handed to the datapath in one launch (power of two).
  localparam int unsigned DEF_CHUNK_BYTES = 4096;
  // AXI data beat size; every chunk is a whole number of beats.
  localparam int unsigned DEF_BEAT_BYTES  = 64;

endpackage : kernel_ctrl_pkg

// File: rtl/kernel_chunk_sequencer.sv
// ---------------------------------------------------------------------------
// kernel_chunk_sequencer
// Splits one host job (base address + byte length) into a series of datapath
// launches of at most C_CHUNK_BYTES each. The job length is first rounded up
// to a whole number of AXI beats. Each chunk is launched with a one-cycle
// dp_start pulse and the sequencer waits for dp_done before the next one.
//
// Ports
//   ap_clk, areset          clock, synchronous active-high reset
//   ap_start                host start level (rising edge starts a job)
//   ap_idle                 high only while no job is in progress
//   ap_done, ap_ready       one-cycle job-complete pulse
//   ctrl_base_addr          job start byte address
//   ctrl_length_bytes       total job bytes
//   dp_start                one-cycle launch pulse to the datapath
//   dp_addr_offset          chunk byte address (held until dp_done)
//   dp_xfer_size_in_bytes   chunk byte size (held until dp_done)
//   dp_done                 datapath chunk-complete pulse
//   chunk_count             chunks completed in the current / last job
//   proto_err               sticky: dp_done seen while not waiting for it
// ---------------------------------------------------------------------------
module kernel_chunk_sequencer
  import kernel_ctrl_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_CHUNK_BYTES     = DEF_CHUNK_BYTES,
  parameter int unsigned C_BEAT_BYTES      = DEF_BEAT_BYTES
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_base_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_length_bytes,
  output logic                         dp_start,
  output logic [C_ADDR_WIDTH-1:0]      dp_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0] dp_xfer_size_in_bytes,
  input  logic                         dp_done,
  output logic [15:0]                  chunk_count,
  output logic                         proto_err
);

  // Remaining-byte arithmetic carries one extra bit so that rounding a
  // near-maximum length up to the next beat cannot wrap to zero.
  localparam int unsigned RW = C_XFER_SIZE_WIDTH + 1;
  localparam logic [RW-1:0] BEAT_M1  = RW'(C_BEAT_BYTES - 1);
  localparam logic [RW-1:0] CHUNK_RW = RW'(C_CHUNK_BYTES);

  seq_state_e                   state_q;
  logic                         ap_start_r_q;
  logic                         ap_idle_q;
  logic                         ap_done_q;
  logic                         dp_start_q;
  logic [C_ADDR_WIDTH-1:0]      dp_addr_q;
  logic [C_XFER_SIZE_WIDTH-1:0] dp_size_q;
  logic [C_ADDR_WIDTH-1:0]      cur_addr_q;
  logic [RW-1:0]                remaining_q;
  logic [15:0]                  chunk_cnt_q;
  logic                         proto_err_q;

  logic                         start_pulse;
  logic [RW-1:0]                len_rnd;
  logic [RW-1:0]                rem_after;
  logic [C_ADDR_WIDTH-1:0]      addr_after;

  // Size of the next launch given the bytes still outstanding.
  function automatic logic [C_XFER_SIZE_WIDTH-1:0] chunk_of(input logic [RW-1:0] rem);
    return (rem < CHUNK_RW) ? C_XFER_SIZE_WIDTH'(rem) : C_XFER_SIZE_WIDTH'(CHUNK_RW);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    start_pulse = ap_start & ~ap_start_r_q;
    len_rnd     = ({1'b0, ctrl_length_bytes} + BEAT_M1) & ~BEAT_M1;
    // dp_size_q still holds the chunk in flight while in WAIT.
    rem_after   = remaining_q - RW'(dp_size_q);
    addr_after  = cur_addr_q + C_ADDR_WIDTH'(dp_size_q);
  end

  // Outputs for the next state are computed on the transition into it, so
  // every output is a plain register aligned with the state it belongs to.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      ap_start_r_q <= 1'b0;
      ap_idle_q    <= 1'b1;
      ap_done_q    <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_addr_q    <= '0;
      dp_size_q    <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      chunk_cnt_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      ap_start_r_q <= ap_start;

      // A completion is only legal while a chunk is outstanding.
      if (dp_done && (state_q != ST_WAIT)) begin
        proto_err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            cur_addr_q  <= ctrl_base_addr;
            remaining_q <= len_rnd;
            chunk_cnt_q <= '0;
            ap_idle_q   <= 1'b0;
            if (len_rnd == '0) begin
              state_q   <= ST_DONE;
              ap_done_q <= 1'b1;
            end else begin
              state_q    <= ST_LAUNCH;
              dp_start_q <= 1'b1;
              dp_addr_q  <= ctrl_base_addr;
              dp_size_q  <= chunk_of(len_rnd);
            end
          end
        end

        ST_LAUNCH: begin
          dp_start_q <= 1'b0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (dp_done) begin
            cur_addr_q  <= addr_after;
            remaining_q <= rem_after;
            chunk_cnt_q <= sat_inc16(chunk_cnt_q);
            if (rem_after == '0) begin
              state_q   <= ST_DONE;
              ap_done_q <= 1'b1;
            end else begin
              state_q    <= ST_LAUNCH;
              dp_start_q <= 1'b1;
              dp_addr_q  <= addr_after;
              dp_size_q  <= chunk_of(rem_after);
            end
          end
        end

        ST_DONE: begin
          // Any start edge seen here is dropped; the host must re-raise.
          ap_done_q <= 1'b0;
          ap_idle_q <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ap_idle               = ap_idle_q;
  assign ap_done               = ap_done_q;
  assign ap_ready              = ap_done_q;
  assign dp_start              = dp_start_q;
  assign dp_addr_offset        = dp_addr_q;
  assign dp_xfer_size_in_bytes = dp_size_q;
  assign chunk_count           = chunk_cnt_q;
  assign proto_err             = proto_err_q;

endmodule : kernel_chunk_sequencer

// File: tb/tb_kernel_chunk_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kernel_chunk_sequencer
// Directed bench for kernel_chunk_sequencer. A job-level model turns
// (base, length) into the list of chunks the datapath must see; a monitor
// compares every dp_start and ap_done against it, and directed checks cover
// reset, idle handshake, zero length, held start, stray dp_done and abort.
// ---------------------------------------------------------------------------
module tb_kernel_chunk_sequencer;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] size;
  } chunk_t;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic        ap_ready;
  logic [63:0] ctrl_base_addr;
  logic [31:0] ctrl_length_bytes;
  logic        dp_start;
  logic [63:0] dp_addr_offset;
  logic [31:0] dp_xfer_size_in_bytes;
  logic        dp_done;
  logic [15:0] chunk_count;
  logic        proto_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  chunk_t exp_q[$];
  int     exp_count    = 0;
  int     jobs_pending = 0;
  int     done_seen    = 0;
  int     starts_seen  = 0;
  int     cyc          = 0;
  int     last_start   = 0;
  int     last_gap     = 0;
  bit     mon_en       = 1'b0;
  bit     in_flight    = 1'b0;
  logic [63:0] hold_addr;
  logic [31:0] hold_size;
  chunk_t mon_c;

  int resp_lat   = 1;
  int cd         = 0;
  bit inject_req = 1'b0;

  always #5 ap_clk = ~ap_clk;

  kernel_chunk_sequencer dut (
    .ap_clk                (ap_clk),
    .areset                (areset),
    .ap_start              (ap_start),
    .ap_idle               (ap_idle),
    .ap_done               (ap_done),
    .ap_ready              (ap_ready),
    .ctrl_base_addr        (ctrl_base_addr),
    .ctrl_length_bytes     (ctrl_length_bytes),
    .dp_start              (dp_start),
    .dp_addr_offset        (dp_addr_offset),
    .dp_xfer_size_in_bytes (dp_xfer_size_in_bytes),
    .dp_done               (dp_done),
    .chunk_count           (chunk_count),
    .proto_err             (proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Job model: round the length up to whole 64-byte beats, then peel off
  // chunks of at most 4096 bytes at consecutive addresses.
  task automatic model_job(input logic [63:0] base, input logic [31:0] len, output int n);
    longint unsigned rem;
    longint unsigned sz;
    logic [63:0]     a;
    chunk_t          c;
    rem = len;
    rem = ((rem + 64'd63) / 64'd64) * 64'd64;
    a   = base;
    n   = 0;
    while (rem > 0) begin
      sz     = (rem > 64'd4096) ? 64'd4096 : rem;
      c.addr = a;
      c.size = sz[31:0];
      exp_q.push_back(c);
      a   = a + sz;
      rem = rem - sz;
      n++;
    end
  endtask

  // Datapath stand-in: answers each dp_start with a dp_done resp_lat cycles
  // later, and can also emit one unsolicited dp_done on request.
  initial begin
    dp_done = 1'b0;
    forever begin
      @(negedge ap_clk);
      dp_done = 1'b0;
      if (inject_req) begin
        dp_done    = 1'b1;
        inject_req = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) dp_done = 1'b1;
      end
      if (dp_start) cd = resp_lat;
    end
  end

  // Compare process: checks every launch and every completion.
  always @(posedge ap_clk) begin
    #1;
    cyc++;
    if (!mon_en) begin
      in_flight = 1'b0;
    end else begin
      if (in_flight) begin
        if (dp_done) begin
          in_flight = 1'b0;
        end else begin
          check("hold_addr", dp_addr_offset, hold_addr);
          check("hold_size", dp_xfer_size_in_bytes, hold_size);
        end
      end
      if (dp_start) begin
        starts_seen++;
        last_gap   = cyc - last_start;
        last_start = cyc;
        check("dp_start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_c = exp_q.pop_front();
          check("chunk_addr", dp_addr_offset, mon_c.addr);
          check("chunk_size", dp_xfer_size_in_bytes, mon_c.size);
        end
        hold_addr = dp_addr_offset;
        hold_size = dp_xfer_size_in_bytes;
        in_flight = 1'b1;
      end
      if (ap_done) begin
        done_seen++;
        check("ap_ready", ap_ready, 1);
        check("done_expected", jobs_pending != 0, 1);
        if (jobs_pending != 0) begin
          jobs_pending--;
          check("chunks_left", exp_q.size(), 0);
          check("chunk_count", chunk_count, exp_count);
        end
      end
    end
  end

  task automatic wait_done(input int d0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge ap_clk);
      #2;
      if (done_seen > d0) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", got, 1);
  endtask

  task automatic run_job(input logic [63:0] base, input logic [31:0] len, input int n,
                         input int lat, input bit repulse, input bit hold);
    int d0;
    exp_count = n;
    jobs_pending++;
    resp_lat          = lat;
    ctrl_base_addr    = base;
    ctrl_length_bytes = len;
    d0 = done_seen;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #2;
    check("idle_fall", ap_idle, 0);
    if (repulse) begin
      @(negedge ap_clk); ap_start = 1'b0;
      @(negedge ap_clk); ap_start = 1'b1;
      @(negedge ap_clk); ap_start = 1'b0;
    end
    wait_done(d0);
    @(posedge ap_clk);
    #2;
    check("idle_rise", ap_idle, 1);
    check("done_one_cycle", ap_done, 0);
    check("one_done_per_job", done_seen, d0 + 1);
    if (!hold) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
  endtask

  initial begin
    int n;
    int s0;
    int d0;
    bit got;

    areset            = 1'b1;
    ap_start          = 1'b0;
    ctrl_base_addr    = '0;
    ctrl_length_bytes = '0;
    repeat (3) @(posedge ap_clk);
    #2;
    check("rst_ap_idle",   ap_idle, 1);
    check("rst_ap_done",   ap_done, 0);
    check("rst_ap_ready",  ap_ready, 0);
    check("rst_dp_start",  dp_start, 0);
    check("rst_dp_addr",   dp_addr_offset, 0);
    check("rst_dp_size",   dp_xfer_size_in_bytes, 0);
    check("rst_count",     chunk_count, 0);
    check("rst_proto_err", proto_err, 0);
    @(negedge ap_clk);
    areset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge ap_clk);

    // Four full chunks, fastest datapath response.
    model_job(64'h1000, 32'd16384, n);
    check("model_a_n", n, 4);
    check("model_a_addr3", exp_q[3].addr, 64'h4000);
    check("model_a_size0", exp_q[0].size, 32'd4096);
    run_job(64'h1000, 32'd16384, n, 1, 1'b0, 1'b0);
    check("a_final_count", chunk_count, 16'd4);
    check("a_min_interval", last_gap, 2);

    // Ragged length rounded up to beats; a second start edge mid-job is dropped.
    model_job(64'h20000, 32'd5000, n);
    check("model_b_n", n, 2);
    check("model_b_size1", exp_q[1].size, 32'd960);
    run_job(64'h20000, 32'd5000, n, 3, 1'b1, 1'b0);
    check("b_final_count", chunk_count, 16'd2);

    // Zero length: ap_done in the second cycle counting the start_pulse cycle.
    exp_count = 0;
    jobs_pending++;
    ctrl_base_addr    = 64'h5000;
    ctrl_length_bytes = 32'd0;
    s0 = starts_seen;
    d0 = done_seen;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #2;
    check("len0_done", ap_done, 1);
    check("len0_idle_low", ap_idle, 0);
    @(posedge ap_clk);
    #2;
    check("len0_done_drop", ap_done, 0);
    check("len0_idle_back", ap_idle, 1);
    check("len0_done_count", done_seen, d0 + 1);
    check("len0_no_launch", starts_seen, s0);
    check("len0_count", chunk_count, 16'd0);
    @(negedge ap_clk);
    ap_start = 1'b0;
    @(negedge ap_clk);

    // Held start level must not relaunch; a fresh rising edge must.
    model_job(64'h8000, 32'd100, n);
    check("model_c_size0", exp_q[0].size, 32'd128);
    run_job(64'h8000, 32'd100, n, 2, 1'b0, 1'b1);
    s0 = starts_seen;
    d0 = done_seen;
    repeat (20) @(posedge ap_clk);
    #2;
    check("held_idle", ap_idle, 1);
    check("held_no_launch", starts_seen, s0);
    check("held_no_done", done_seen, d0);
    @(negedge ap_clk);
    ap_start = 1'b0;
    model_job(64'h9000, 32'd200, n);
    run_job(64'h9000, 32'd200, n, 2, 1'b0, 1'b0);
    check("d_final_count", chunk_count, 16'd1);
    check("proto_err_clean", proto_err, 0);

    // Stray dp_done while idle.
    s0 = starts_seen;
    @(negedge ap_clk);
    inject_req = 1'b1;
    repeat (3) @(posedge ap_clk);
    #2;
    check("stray_proto_err", proto_err, 1);
    check("stray_idle", ap_idle, 1);
    check("stray_count", chunk_count, 16'd1);
    check("stray_no_launch", starts_seen, s0);

    // Abort with reset while chunk 2 is outstanding.
    model_job(64'h1000, 32'd16384, n);
    exp_count = n;
    jobs_pending++;
    resp_lat          = 5;
    ctrl_base_addr    = 64'h1000;
    ctrl_length_bytes = 32'd16384;
    s0 = starts_seen;
    @(negedge ap_clk);
    ap_start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge ap_clk);
      #2;
      if (starts_seen >= s0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    check("reach_chunk2", got, 1);
    @(posedge ap_clk);
    #2;
    d0 = done_seen;
    @(negedge ap_clk);
    areset   = 1'b1;
    ap_start = 1'b0;
    mon_en   = 1'b0;
    @(posedge ap_clk);
    #2;
    check("abort_idle",      ap_idle, 1);
    check("abort_done",      ap_done, 0);
    check("abort_ready",     ap_ready, 0);
    check("abort_dp_start",  dp_start, 0);
    check("abort_dp_addr",   dp_addr_offset, 0);
    check("abort_dp_size",   dp_xfer_size_in_bytes, 0);
    check("abort_count",     chunk_count, 0);
    check("abort_proto_err", proto_err, 0);
    @(negedge ap_clk);
    areset = 1'b0;
    exp_q.delete();
    jobs_pending = 0;
    repeat (8) @(posedge ap_clk);
    #2;
    check("late_done_proto_err", proto_err, 1);
    check("late_no_ap_done", done_seen, d0);
    check("late_idle", ap_idle, 1);
    mon_en = 1'b1;

    // Sequencer still works after the abort.
    model_job(64'hA000, 32'd64, n);
    run_job(64'hA000, 32'd64, n, 1, 1'b0, 1'b0);
    check("post_abort_count", chunk_count, 16'd1);

    repeat (3) @(posedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kernel_chunk_sequencer
